sram_like_resp: RTL and testbench

Responder (slave) end of the team's sram-like bus: it accepts `req`/`addrok` address handshakes and returns in-order `dataok`/`rdata` responses after a fixed latency. It is backed by a local word-addressed memory. It stands in for the instruction or data memory behind the CPU's fetch and memory stages in block and SoC benches, and in the FPGA-less simulation top. Supports multiple outstanding requests, byte-strobed writes and back-pressure on the address channel.

---
 rtl/sram_like_resp.sv | 80 ++++++++
 tb/tb_sram_like_resp.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_resp.sv
// Responder end of the sram-like bus: accepts req/addrok handshakes and
// returns in-order dataok/rdata after a fixed latency from a local word memory.
module sram_like_resp #(
  parameter int AW      = 10,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addrok,
  output logic        dataok,
  output logic [31:0] rdata
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   mem    [0:(1<<AW)-1];
  logic [31:0]   q_data [0:QDEPTH-1];
  logic [3:0]    q_age  [0:QDEPTH-1];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [AW-1:0] idx;
  logic          accept;
  logic          unused;

  assign idx    = addr[AW+1:2];
  assign unused = ^{size, addr[31:AW+2], addr[1:0]};

  // Gated by resetn so the handshake is refused while reset is held.
  assign addrok = resetn && (count < CW'(QDEPTH));
  assign accept = req && addrok;
  assign dataok = (count != '0) && (q_age[head] == 4'd0);
  assign rdata  = dataok ? q_data[head] : 32'h0;

  // Memory is deliberately not reset; contents survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_age[i]  <= 4'd0;
        q_data[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_age[i] != 4'd0) q_age[i] <= q_age[i] - 4'd1;
      end
      // The tail slot is free (age 0), so this push overrides its decrement.
      if (accept) begin
        q_data[tail] <= wr ? 32'h0 : mem[idx];
        q_age[tail]  <= 4'(LATENCY - 1);
        tail         <= tail + 1'b1;
      end
      if (dataok) head <= head + 1'b1;
      case ({accept, dataok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: three differently parameterised instances checked
// every cycle against a due-cycle based reference model of the bus responder.
module tb_sram_like_resp;

  localparam int NI = 3;

  int p_aw [NI] = '{10, 6, 4};
  int p_lat[NI] = '{2, 6, 1};
  int p_qd [NI] = '{4, 2, 2};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req   [NI];
  logic        wr    [NI];
  logic [1:0]  size  [NI];
  logic [31:0] addr  [NI];
  logic [3:0]  wstrb [NI];
  logic [31:0] wdata [NI];
  logic        addrok[NI];
  logic        dataok[NI];
  logic [31:0] rdata [NI];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_like_resp #(.AW(10), .LATENCY(2), .QDEPTH(4)) u0 (
    .clk(clk), .resetn(resetn), .req(req[0]), .wr(wr[0]), .size(size[0]),
    .addr(addr[0]), .wstrb(wstrb[0]), .wdata(wdata[0]),
    .addrok(addrok[0]), .dataok(dataok[0]), .rdata(rdata[0]));

  sram_like_resp #(.AW(6), .LATENCY(6), .QDEPTH(2)) u1 (
    .clk(clk), .resetn(resetn), .req(req[1]), .wr(wr[1]), .size(size[1]),
    .addr(addr[1]), .wstrb(wstrb[1]), .wdata(wdata[1]),
    .addrok(addrok[1]), .dataok(dataok[1]), .rdata(rdata[1]));

  sram_like_resp #(.AW(4), .LATENCY(1), .QDEPTH(2)) u2 (
    .clk(clk), .resetn(resetn), .req(req[2]), .wr(wr[2]), .size(size[2]),
    .addr(addr[2]), .wstrb(wstrb[2]), .wdata(wdata[2]),
    .addrok(addrok[2]), .dataok(dataok[2]), .rdata(rdata[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: memory image plus a list of owed responses with due cycles.
  logic [31:0] mm     [NI][1024];
  logic [31:0] rq_d   [NI][64];
  int          rq_due [NI][64];
  int          rq_rd  [NI] = '{0, 0, 0};
  int          rq_wr  [NI] = '{0, 0, 0};
  int          acc_cnt[NI] = '{0, 0, 0};
  int          acc_cyc[NI][64];
  int          resp_cnt[NI] = '{0, 0, 0};
  int          resp_cyc[NI][64];
  logic [31:0] last_rdata[NI];
  int          cyc = 0;

  function automatic int qsize(input int k);
    return rq_wr[k] - rq_rd[k];
  endfunction

  task automatic flush_model();
    for (int k = 0; k < NI; k++) rq_rd[k] = rq_wr[k];
  endtask

  always @(negedge resetn) flush_model();

  always @(posedge clk) begin
    cyc++;
    if (!resetn) begin
      flush_model();
    end else begin
      for (int k = 0; k < NI; k++) begin
        bit acc;
        int ix;
        acc = req[k] && (qsize(k) < p_qd[k]);
        if (qsize(k) > 0 && rq_due[k][rq_rd[k] % 64] == cyc - 1) rq_rd[k]++;
        if (acc) begin
          ix = int'((addr[k] >> 2) & 32'((1 << p_aw[k]) - 1));
          if (wr[k]) begin
            rq_d[k][rq_wr[k] % 64] = 32'h0;
            for (int b = 0; b < 4; b++)
              if (wstrb[k][b]) mm[k][ix][8*b +: 8] = wdata[k][8*b +: 8];
          end else begin
            rq_d[k][rq_wr[k] % 64] = mm[k][ix];
          end
          rq_due[k][rq_wr[k] % 64] = cyc + p_lat[k] - 1;
          rq_wr[k]++;
          acc_cyc[k][acc_cnt[k] % 64] = cyc;
          acc_cnt[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      bit          e_ok, e_dv;
      logic [31:0] e_rd;
      e_ok = resetn && (qsize(k) < p_qd[k]);
      e_dv = resetn && (qsize(k) > 0) && (rq_due[k][rq_rd[k] % 64] == cyc);
      e_rd = e_dv ? rq_d[k][rq_rd[k] % 64] : 32'h0;
      chk($sformatf("addrok[%0d]", k), 32'(addrok[k]), 32'(e_ok));
      chk($sformatf("dataok[%0d]", k), 32'(dataok[k]), 32'(e_dv));
      chk($sformatf("rdata[%0d]", k), rdata[k], e_rd);
      if (dataok[k] === 1'b1) begin
        last_rdata[k] = rdata[k];
        resp_cyc[k][resp_cnt[k] % 64] = cyc;
        resp_cnt[k]++;
      end
    end
  end

  task automatic steps(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a request and returns just after the edge that accepts it; req stays high.
  task automatic issue(input int k, input bit w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    bit got = 1'b0;
    int n = 0;
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wstrb[k] = s; wdata[k] = d;
    size[k] = 2'($urandom_range(0, 3));
    while (!got && n < 64) begin
      @(negedge clk);
      got = (addrok[k] === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk($sformatf("accept_timeout[%0d]", k), 32'(got), 32'd1);
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0;
    wr[k]  = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (qsize(k) != 0 && n < 100) begin
      steps(1);
      n++;
    end
    if (n >= 100) chk($sformatf("drain_timeout[%0d]", k), 32'(qsize(k)), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0;
    for (int k = 0; k < NI; k++) begin
      req[k] = 0; wr[k] = 0; size[k] = 0; addr[k] = 0; wstrb[k] = 0; wdata[k] = 0;
    end
    steps(2);
    chk("reset_addrok", 32'(addrok[0]), 32'd0);
    chk("reset_dataok", 32'(dataok[0]), 32'd0);
    resetn = 1'b1;
    #1;
    chk("release_addrok", 32'(addrok[0]), 32'd1);
    steps(1);

    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < (1 << p_aw[k]); i++) issue(k, 1'b1, 32'(i << 2), 4'hF, $urandom);
      idle(k);
      drain(k);
    end

    // Basic write then read.
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF); idle(0); drain(0);
    chk("wr_rdata", last_rdata[0], 32'h0);
    chk("wr_latency", 32'(resp_cyc[0][(resp_cnt[0]-1) % 64] - acc_cyc[0][(acc_cnt[0]-1) % 64]), 32'd1);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0); idle(0); drain(0);
    chk("rd_rdata", last_rdata[0], 32'hDEADBEEF);
    chk("rd_latency", 32'(resp_cyc[0][(resp_cnt[0]-1) % 64] - acc_cyc[0][(acc_cnt[0]-1) % 64]), 32'd1);

    // Byte strobes.
    issue(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
    issue(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0);
    idle(0); drain(0);
    chk("strobe_merge", last_rdata[0], 32'h11BB33DD);

    // Streaming reads of words preloaded with 0..7.
    for (int i = 0; i < 8; i++) issue(0, 1'b1, 32'h100 + 32'(i*4), 4'hF, 32'(i));
    idle(0); drain(0);
    a0 = acc_cnt[0]; r0 = resp_cnt[0];
    for (int i = 0; i < 8; i++) issue(0, 1'b0, 32'h100 + 32'(i*4), 4'h0, 32'h0);
    idle(0); drain(0);
    chk("stream_accept_span", 32'(acc_cyc[0][(a0+7) % 64] - acc_cyc[0][a0 % 64]), 32'd7);
    chk("stream_resp_span", 32'(resp_cyc[0][(r0+7) % 64] - resp_cyc[0][r0 % 64]), 32'd7);
    chk("stream_resp_count", 32'(resp_cnt[0] - r0), 32'd8);
    chk("stream_last", last_rdata[0], 32'd7);

    // Back-pressure: a full queue refuses even on a popping edge, so two
    // accepts repeat every LATENCY+1 cycles.
    a0 = acc_cnt[1]; r0 = resp_cnt[1];
    for (int i = 0; i < 12; i++) issue(1, 1'b0, $urandom, 4'h0, 32'h0);
    idle(1); drain(1);
    chk("bp_first_latency", 32'(resp_cyc[1][r0 % 64] - acc_cyc[1][a0 % 64]), 32'd5);
    chk("bp_resp_count", 32'(resp_cnt[1] - r0), 32'd12);
    for (int j = 0; j < 10; j++)
      chk($sformatf("bp_period_%0d", j),
          32'(acc_cyc[1][(a0+j+2) % 64] - acc_cyc[1][(a0+j) % 64]), 32'(p_lat[1] + 1));

    // Reset in flight.
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0);
    issue(0, 1'b0, 32'h30, 4'h0, 32'h0);
    idle(0);
    #1 resetn = 1'b0;
    #1;
    chk("rst_dataok", 32'(dataok[0]), 32'd0);
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_addrok", 32'(addrok[0]), 32'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    #1;
    chk("rst_release_addrok", 32'(addrok[0]), 32'd1);
    r0 = resp_cnt[0];
    steps(8);
    chk("rst_no_stale_resp", 32'(resp_cnt[0] - r0), 32'd0);
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0); idle(0); drain(0);
    chk("rst_mem_retained", last_rdata[0], 32'hDEADBEEF);

    // Aliasing plus read-after-write on consecutive accepts.
    issue(2, 1'b1, 32'h40, 4'hF, 32'h5);
    issue(2, 1'b0, 32'h00, 4'h0, 32'h0);
    idle(2); drain(2);
    chk("alias_raw", last_rdata[2], 32'h5);

    // Randomised traffic with idle gaps.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 300; i++) begin
        int gap = $urandom_range(0, 2);
        if (gap != 0) begin
          idle(k);
          steps(gap);
        end
        issue(k, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
      end
      idle(k);
      drain(k);
    end

    steps(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
